// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//
// ID/EX pipeline register plus the operand-forwarding front end of the
// execute stage. Decoded operands and control are captured from decode.
// Read-after-write hazards are resolved by forwarding from EX/MEM (youngest
// producer) and MEM/WB. The resolved operands feed the adder/subtractor/SLT
// ALU.
//
// Ports
//   CLK, RST                 rising-edge clock, async active-high reset
//   VALID_ID                 decode slot holds a real instruction
//   RS1_DATA_ID/RS2_DATA_ID  register-file read data
//   IMM_ID                   sign-extended immediate
//   RS1/RS2/RD_ADDR_ID       register indices
//   ALU_SRC_ID               1 = operand 2 is the immediate
//   SUB_ID                   ALU carry-in / subtract-compare select
//   REG_WRITE_ID             instruction writes RD
//   STALL, FLUSH             hold / bubble-insert the ID/EX register
//   EXMEM_*, MEMWB_*         forwarding sources (rd, write enable, result)
//   ALU_IN1, ALU_IN2         forwarded ALU operands
//   ALU_CIN                  registered SUB
//   RS2_FWD_EX               forwarded rs2 (store data), ignores ALU_SRC
//   RD_ADDR_EX, REG_WRITE_EX, VALID_EX   registered control
// ---------------------------------------------------------------------------
module id_ex_operand_stage #(
  parameter int N = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         VALID_ID,
  input  logic [N-1:0] RS1_DATA_ID,
  input  logic [N-1:0] RS2_DATA_ID,
  input  logic [N-1:0] IMM_ID,
  input  logic [4:0]   RS1_ADDR_ID,
  input  logic [4:0]   RS2_ADDR_ID,
  input  logic [4:0]   RD_ADDR_ID,
  input  logic         ALU_SRC_ID,
  input  logic         SUB_ID,
  input  logic         REG_WRITE_ID,
  input  logic         STALL,
  input  logic         FLUSH,
  input  logic [4:0]   EXMEM_RD,
  input  logic         EXMEM_REG_WRITE,
  input  logic [N-1:0] EXMEM_RESULT,
  input  logic [4:0]   MEMWB_RD,
  input  logic         MEMWB_REG_WRITE,
  input  logic [N-1:0] MEMWB_RESULT,
  output logic [N-1:0] ALU_IN1,
  output logic [N-1:0] ALU_IN2,
  output logic         ALU_CIN,
  output logic [N-1:0] RS2_FWD_EX,
  output logic [4:0]   RD_ADDR_EX,
  output logic         REG_WRITE_EX,
  output logic         VALID_EX
);

  logic         r_valid;
  logic [N-1:0] r_rs1_data;
  logic [N-1:0] r_rs2_data;
  logic [N-1:0] r_imm;
  logic [4:0]   r_rs1_addr;
  logic [4:0]   r_rs2_addr;
  logic [4:0]   r_rd_addr;
  logic         r_alu_src;
  logic         r_sub;
  logic         r_reg_write;

  logic         w_refresh1;
  logic         w_refresh2;
  logic [N-1:0] w_fwd1;
  logic [N-1:0] w_fwd2;

  // Operand select for one source register. x0 is never forwarded; EX/MEM
  // beats MEM/WB because it holds the younger producer.
  function automatic logic [N-1:0] fwd_sel(
    input logic [4:0]   rs,
    input logic [N-1:0] held,
    input logic [4:0]   exmem_rd,
    input logic         exmem_we,
    input logic [N-1:0] exmem_res,
    input logic [4:0]   memwb_rd,
    input logic         memwb_we,
    input logic [N-1:0] memwb_res
  );
    logic [N-1:0] sel;
    sel = held;
    if (rs != 5'd0) begin
      if (exmem_we && (exmem_rd == rs))
        sel = exmem_res;
      else if (memwb_we && (memwb_rd == rs))
        sel = memwb_res;
    end
    return sel;
  endfunction

  // While stalled, a MEM/WB write to a held source must be captured: the
  // producer retires during the stall and would otherwise vanish from the
  // forwarding network before this instruction executes.
  assign w_refresh1 = MEMWB_REG_WRITE && (MEMWB_RD != 5'd0) && (MEMWB_RD == r_rs1_addr);
  assign w_refresh2 = MEMWB_REG_WRITE && (MEMWB_RD != 5'd0) && (MEMWB_RD == r_rs2_addr);

  // ---- ID -> EX register boundary ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_alu_src   <= 1'b0;
      r_sub       <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (FLUSH) begin
      r_valid     <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
      r_rd_addr   <= 5'd0;
      r_alu_src   <= 1'b0;
      r_sub       <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (STALL) begin
      if (w_refresh1) r_rs1_data <= MEMWB_RESULT;
      if (w_refresh2) r_rs2_data <= MEMWB_RESULT;
    end else begin
      r_valid     <= VALID_ID;
      r_rs1_data  <= RS1_DATA_ID;
      r_rs2_data  <= RS2_DATA_ID;
      r_imm       <= IMM_ID;
      r_rs1_addr  <= RS1_ADDR_ID;
      r_rs2_addr  <= RS2_ADDR_ID;
      r_rd_addr   <= RD_ADDR_ID;
      r_alu_src   <= ALU_SRC_ID;
      r_sub       <= SUB_ID;
      // A bubble in decode must never write the register file.
      r_reg_write <= REG_WRITE_ID & VALID_ID;
    end
  end

  // ---- EX stage: combinational forwarding ----
  assign w_fwd1 = fwd_sel(r_rs1_addr, r_rs1_data, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
                          MEMWB_RD, MEMWB_REG_WRITE, MEMWB_RESULT);
  assign w_fwd2 = fwd_sel(r_rs2_addr, r_rs2_data, EXMEM_RD, EXMEM_REG_WRITE, EXMEM_RESULT,
                          MEMWB_RD, MEMWB_REG_WRITE, MEMWB_RESULT);

  assign ALU_IN1      = w_fwd1;
  assign ALU_IN2      = r_alu_src ? r_imm : w_fwd2;
  assign RS2_FWD_EX   = w_fwd2;
  assign ALU_CIN      = r_sub;
  assign RD_ADDR_EX   = r_rd_addr;
  assign REG_WRITE_EX = r_reg_write;
  assign VALID_EX     = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  localparam int N = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         VALID_ID;
  logic [N-1:0] RS1_DATA_ID, RS2_DATA_ID, IMM_ID;
  logic [4:0]   RS1_ADDR_ID, RS2_ADDR_ID, RD_ADDR_ID;
  logic         ALU_SRC_ID, SUB_ID, REG_WRITE_ID;
  logic         STALL, FLUSH;
  logic [4:0]   EXMEM_RD;
  logic         EXMEM_REG_WRITE;
  logic [N-1:0] EXMEM_RESULT;
  logic [4:0]   MEMWB_RD;
  logic         MEMWB_REG_WRITE;
  logic [N-1:0] MEMWB_RESULT;
  logic [N-1:0] ALU_IN1, ALU_IN2, RS2_FWD_EX;
  logic         ALU_CIN;
  logic [4:0]   RD_ADDR_EX;
  logic         REG_WRITE_EX, VALID_EX;

  always #5 CLK = ~CLK;

  id_ex_operand_stage #(.N(N)) dut (
    .CLK(CLK), .RST(RST), .VALID_ID(VALID_ID),
    .RS1_DATA_ID(RS1_DATA_ID), .RS2_DATA_ID(RS2_DATA_ID), .IMM_ID(IMM_ID),
    .RS1_ADDR_ID(RS1_ADDR_ID), .RS2_ADDR_ID(RS2_ADDR_ID), .RD_ADDR_ID(RD_ADDR_ID),
    .ALU_SRC_ID(ALU_SRC_ID), .SUB_ID(SUB_ID), .REG_WRITE_ID(REG_WRITE_ID),
    .STALL(STALL), .FLUSH(FLUSH),
    .EXMEM_RD(EXMEM_RD), .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RESULT(EXMEM_RESULT),
    .MEMWB_RD(MEMWB_RD), .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RESULT(MEMWB_RESULT),
    .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_CIN(ALU_CIN), .RS2_FWD_EX(RS2_FWD_EX),
    .RD_ADDR_EX(RD_ADDR_EX), .REG_WRITE_EX(REG_WRITE_EX), .VALID_EX(VALID_EX)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] in1, input logic [N-1:0] in2,
                         input logic cin, input logic [N-1:0] f2, input logic [4:0] rd,
                         input logic rw, input logic vld);
    chk({tag, ".ALU_IN1"}, ALU_IN1, in1);
    chk({tag, ".ALU_IN2"}, ALU_IN2, in2);
    chk({tag, ".ALU_CIN"}, N'(ALU_CIN), N'(cin));
    chk({tag, ".RS2_FWD_EX"}, RS2_FWD_EX, f2);
    chk({tag, ".RD_ADDR_EX"}, N'(RD_ADDR_EX), N'(rd));
    chk({tag, ".REG_WRITE_EX"}, N'(REG_WRITE_EX), N'(rw));
    chk({tag, ".VALID_EX"}, N'(VALID_EX), N'(vld));
  endtask

  task automatic set_id(input logic v, input logic [N-1:0] d1, input logic [N-1:0] d2,
                        input logic [N-1:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic src, input logic sub, input logic rw);
    VALID_ID = v; RS1_DATA_ID = d1; RS2_DATA_ID = d2; IMM_ID = imm;
    RS1_ADDR_ID = a1; RS2_ADDR_ID = a2; RD_ADDR_ID = rd;
    ALU_SRC_ID = src; SUB_ID = sub; REG_WRITE_ID = rw;
  endtask

  task automatic set_fwd(input logic [4:0] exrd, input logic exw, input logic [N-1:0] exres,
                         input logic [4:0] mwrd, input logic mww, input logic [N-1:0] mwres);
    EXMEM_RD = exrd; EXMEM_REG_WRITE = exw; EXMEM_RESULT = exres;
    MEMWB_RD = mwrd; MEMWB_REG_WRITE = mww; MEMWB_RESULT = mwres;
  endtask

  task automatic edge1();
    @(posedge CLK); #1;
  endtask

  // ---------------- reference model (instruction held in EX) ----------------
  typedef struct {
    logic         valid;
    logic [N-1:0] d1, d2, imm;
    logic [4:0]   a1, a2, rd;
    logic         alusrc, sub, regw;
  } held_t;
  held_t m;

  function automatic logic [N-1:0] operand(input logic [4:0] a, input logic [N-1:0] d);
    if (a == 0) return d;
    if (EXMEM_REG_WRITE && EXMEM_RD == a) return EXMEM_RESULT;
    if (MEMWB_REG_WRITE && MEMWB_RD == a) return MEMWB_RESULT;
    return d;
  endfunction

  task automatic model_clear();
    m.valid = 0; m.d1 = 0; m.d2 = 0; m.imm = 0; m.a1 = 0; m.a2 = 0; m.rd = 0;
    m.alusrc = 0; m.sub = 0; m.regw = 0;
  endtask

  task automatic model_edge();
    if (FLUSH) model_clear();
    else if (STALL) begin
      if (MEMWB_REG_WRITE && MEMWB_RD != 0 && MEMWB_RD == m.a1) m.d1 = MEMWB_RESULT;
      if (MEMWB_REG_WRITE && MEMWB_RD != 0 && MEMWB_RD == m.a2) m.d2 = MEMWB_RESULT;
    end else begin
      m.valid = VALID_ID; m.d1 = RS1_DATA_ID; m.d2 = RS2_DATA_ID; m.imm = IMM_ID;
      m.a1 = RS1_ADDR_ID; m.a2 = RS2_ADDR_ID; m.rd = RD_ADDR_ID;
      m.alusrc = ALU_SRC_ID; m.sub = SUB_ID; m.regw = REG_WRITE_ID && VALID_ID;
    end
  endtask

  task automatic model_check(input string tag);
    logic [N-1:0] o1, o2;
    o1 = operand(m.a1, m.d1);
    o2 = operand(m.a2, m.d2);
    chk_all(tag, o1, m.alusrc ? m.imm : o2, m.sub, o2, m.rd, m.regw, m.valid);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic         vld;
    logic [N-1:0] d1, d2, imm;
    logic [4:0]   a1, a2, rd;
    logic         src, sub, rw;
    logic [4:0]   exrd; logic exw; logic [N-1:0] exres;
    logic [4:0]   mwrd; logic mww; logic [N-1:0] mwres;
    logic [N-1:0] e_in1, e_in2, e_f2;
    logic         e_cin;
    logic [4:0]   e_rd;
    logic         e_rw, e_vld;
  } vec_t;

  vec_t vt[7];

  initial begin
    // plain load, no forwarding
    vt[0] = '{1, 32'h10, 32'h5, 32'h0, 5'd1, 5'd2, 5'd3, 0, 1, 1,
              5'd0, 0, 32'h0, 5'd0, 0, 32'h0,
              32'h10, 32'h5, 32'h5, 1, 5'd3, 1, 1};
    // both sources match -> EX/MEM wins
    vt[1] = '{1, 32'hAAA, 32'hBBB, 32'h0, 5'd4, 5'd4, 5'd6, 0, 0, 1,
              5'd4, 1, 32'h111, 5'd4, 1, 32'h222,
              32'h111, 32'h111, 32'h111, 0, 5'd6, 1, 1};
    // EX/MEM not writing -> MEM/WB used
    vt[2] = '{1, 32'hAAA, 32'hBBB, 32'h0, 5'd4, 5'd4, 5'd6, 0, 0, 1,
              5'd4, 0, 32'h111, 5'd4, 1, 32'h222,
              32'h222, 32'h222, 32'h222, 0, 5'd6, 1, 1};
    // x0 never forwarded, immediate selected, store data still forwarded
    vt[3] = '{1, 32'h0, 32'h55, 32'hFFFF_FFF0, 5'd0, 5'd5, 5'd1, 1, 0, 1,
              5'd0, 1, 32'hFFFF, 5'd5, 1, 32'h5A5A,
              32'h0, 32'hFFFF_FFF0, 32'h5A5A, 0, 5'd1, 1, 1};
    // invalid slot suppresses reg_write
    vt[4] = '{0, 32'h7, 32'h8, 32'h0, 5'd11, 5'd12, 5'd9, 0, 1, 1,
              5'd0, 0, 32'h0, 5'd0, 0, 32'h0,
              32'h7, 32'h8, 32'h8, 1, 5'd9, 0, 0};
    // independent per-operand sources
    vt[5] = '{1, 32'h1, 32'h2, 32'h0, 5'd6, 5'd8, 5'd2, 0, 0, 0,
              5'd8, 1, 32'h800, 5'd6, 1, 32'h600,
              32'h600, 32'h800, 32'h800, 0, 5'd2, 0, 1};
    // matching rd without write enable does not forward
    vt[6] = '{1, 32'h1234, 32'h4321, 32'h0, 5'd10, 5'd31, 5'd31, 0, 1, 1,
              5'd31, 0, 32'hBAD, 5'd10, 0, 32'hBAD,
              32'h1234, 32'h4321, 32'h4321, 1, 5'd31, 1, 1};
  end

  initial begin
    STALL = 0; FLUSH = 0;
    set_id(1, 32'h3, 32'h4, 32'h9, 5'd3, 5'd3, 5'd3, 1, 1, 1);
    set_fwd(5'd3, 1, 32'hDEAD, 5'd3, 1, 32'hBEEF);
    RST = 1;
    #1;
    chk_all("reset_async", 0, 0, 0, 0, 0, 0, 0);
    edge1();
    chk_all("reset_edge", 0, 0, 0, 0, 0, 0, 0);
    RST = 0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 7; i++) begin
      set_id(vt[i].vld, vt[i].d1, vt[i].d2, vt[i].imm, vt[i].a1, vt[i].a2, vt[i].rd,
             vt[i].src, vt[i].sub, vt[i].rw);
      set_fwd(vt[i].exrd, vt[i].exw, vt[i].exres, vt[i].mwrd, vt[i].mww, vt[i].mwres);
      STALL = 0; FLUSH = 0;
      edge1();
      chk_all($sformatf("vec%0d", i), vt[i].e_in1, vt[i].e_in2, vt[i].e_cin, vt[i].e_f2,
              vt[i].e_rd, vt[i].e_rw, vt[i].e_vld);
    end

    // zero-latency forwarding: change EX/MEM with no clock edge
    EXMEM_RD = 5'd10; EXMEM_REG_WRITE = 1; EXMEM_RESULT = 32'hCAFE;
    #1;
    chk("fwd_same_cycle", ALU_IN1, 32'hCAFE);

    // ---- stall refresh ----
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h1, 32'h2, 32'h0, 5'd7, 5'd7, 5'd4, 0, 0, 1);
    edge1();
    chk("sr_load", ALU_IN1, 32'h1);
    STALL = 1;
    set_id(1, 32'hEEE, 32'hEEE, 32'h0, 5'd1, 5'd1, 5'd1, 0, 1, 1);
    edge1();
    chk("sr_hold1", ALU_IN1, 32'h1);
    MEMWB_RD = 5'd7; MEMWB_REG_WRITE = 1; MEMWB_RESULT = 32'h99;
    #1;
    chk("sr_fwd", ALU_IN1, 32'h99);
    edge1();
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    chk("sr_refresh_rs1", ALU_IN1, 32'h99);
    chk("sr_refresh_rs2", RS2_FWD_EX, 32'h99);
    edge1();
    chk("sr_hold3", ALU_IN1, 32'h99);
    chk("sr_hold3_rd", N'(RD_ADDR_EX), N'(5'd4));
    STALL = 0;
    set_id(1, 32'h33, 32'h44, 32'h0, 5'd3, 5'd5, 5'd8, 0, 1, 1);
    edge1();
    chk_all("sr_release", 32'h33, 32'h44, 1, 32'h44, 5'd8, 1, 1);

    // ---- flush beats stall ----
    STALL = 1; FLUSH = 1;
    edge1();
    chk_all("flush_stall", 0, 0, 0, 0, 0, 0, 0);
    FLUSH = 0;

    // ---- reset mid-stall ----
    STALL = 0;
    set_id(1, 32'h77, 32'h88, 32'h0, 5'd9, 5'd10, 5'd12, 0, 1, 1);
    edge1();
    STALL = 1;
    edge1();
    set_fwd(5'd9, 1, 32'h1111, 0, 0, 0);
    #2;
    RST = 1;
    #1;
    chk_all("rst_midstall", 0, 0, 0, 0, 0, 0, 0);
    #1;
    RST = 0;
    STALL = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd3, 0, 0, 1);
    edge1();
    chk_all("rst_after", 32'h5, 32'h6, 0, 32'h6, 5'd3, 1, 1);

    // ---- randomized against reference model ----
    FLUSH = 1; STALL = 0;
    edge1();
    model_clear();
    FLUSH = 0;
    for (int c = 0; c < 400; c++) begin
      set_id($urandom_range(0, 1), $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      set_fwd(5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom,
              5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom);
      STALL = ($urandom_range(0, 9) < 4);
      FLUSH = ($urandom_range(0, 9) == 0);
      #1;
      model_check($sformatf("rand%0d", c));
      @(posedge CLK);
      model_edge();
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
